id_ex_pipeline_reg: RTL and testbench
=====================================

Name: id_ex_pipeline_reg

Overview:
- Pipeline register between the decode and execute stages.
- Captures the two decode-stage operands (top/bot), destination register address and control word, and presents them to the execute stage.
- Uses a valid/ready handshake with a one-entry skid buffer, so a multi-cycle execute unit can back-pressure decode without losing an in-flight instruction.
- Supports synchronous flush for branch/jump squash.

Parameters:
- DATA_WIDTH, 8, width of each operand.
- REG_ADDR_WIDTH, 3, width of the destination register address.
- CTRL_WIDTH, 8, width of the decoded control word; all-zero is NOP.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  squash all held entries.
- id_valid  in  1  decode presents an instruction.
- id_ready  out  1  stage can accept an instruction.
- id_data_top  in  DATA_WIDTH  operand A from decode (register file).
- id_data_bot  in  DATA_WIDTH  operand B from decode (immediate or register file).
- id_dest_reg  in  REG_ADDR_WIDTH  writeback destination.
- id_ctrl  in  CTRL_WIDTH  decoded control word.
- ex_valid  out  1  execute-side entry valid.
- ex_ready  in  1  execute consumes the entry.
- ex_data_top  out  DATA_WIDTH  registered operand A.
- ex_data_bot  out  DATA_WIDTH  registered operand B.
- ex_dest_reg  out  REG_ADDR_WIDTH  registered destination.
- ex_ctrl  out  CTRL_WIDTH  registered control; forced to 0 when ex_valid=0.

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous and active-low.
- Transfer conditions: in_fire = id_valid & id_ready; out_fire = ex_valid & ex_ready.
- Storage:
  - main entry drives the ex_* outputs directly.
  - skid entry is a hidden overflow holding register.
- States: EMPTY, FULL, SKID.
  - id_ready = (state != SKID), decoded from registered state only, with no combinational path from ex_ready.
  - ex_valid = (state != EMPTY).
- Transitions:
  - EMPTY: in_fire -> FULL, main <= inputs.
  - FULL: in_fire & out_fire -> FULL, main <= inputs.
  - FULL: in_fire & !out_fire -> SKID, skid <= inputs.
  - FULL: !in_fire & out_fire -> EMPTY.
  - FULL: neither -> hold.
  - SKID: out_fire -> FULL, main <= skid. No input is accepted because id_ready=0.
  - SKID: no out_fire -> hold.
- Latency: one cycle from in_fire to ex_valid. Throughput: one instruction per cycle when ex_ready is held high.
- Ordering: strict FIFO. Entries are never reordered or duplicated.
- Flush: takes effect on the next edge and has priority over every transfer.
  - state <= EMPTY; an in_fire in the same cycle is dropped.
  - Data registers may retain stale values; ex_ctrl reads 0 because ex_valid=0.
- Reset (rst_n=0 at edge):
  - state=EMPTY; main and skid data, dest and ctrl all cleared to 0.
  - Outputs after reset: ex_valid=0, ex_ctrl=0, ex_data_top=0, ex_data_bot=0, ex_dest_reg=0, id_ready=1.
  - Reset overrides flush and any in-progress skid occupancy.
- Held entry: while ex_valid=1 and ex_ready=0, all ex_* outputs stay stable.
- Precedence of simultaneous events: reset > flush > transfers. There is no priority between in_fire and out_fire; both are applied as per the transition list.
- No arithmetic is performed; widths pass through unchanged.

Decomposition:
- Package id_ex_pkg contains:
  - state encoding (EMPTY=2'b00, FULL=2'b01, SKID=2'b10);
  - CTRL_NOP constant (all zeros);
  - default width constants.
- Sub-module id_ex_entry_reg: load-enabled, synchronously cleared bundle register for data_top, data_bot, dest_reg and ctrl.
  - Instantiated twice: main and skid.
  - Control FSM lives in the top module.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with id_valid=1 -> ex_valid=0, ex_ctrl=0x00, id_ready=1, all data outputs 0x00.
- Streaming: ex_ready=1; send top/bot {0x11/0x22, 0x33/0x44, 0x55/0x66} with ctrl 0x01, 0x02, 0x03 on consecutive cycles -> each appears on ex_* exactly one cycle later, with no bubbles.
- Skid fill and drain:
  - ex_ready=0; send A (0xA1/0xA2), then B (0xB1/0xB2) -> id_ready=0 after B, A held stable.
  - Raise ex_ready -> A consumed, then B, then state EMPTY.
  - No loss or duplication.
- Flush in SKID with id_valid=1, data 0xC1 -> next cycle ex_valid=0, ex_ctrl=0x00, id_ready=1, and 0xC1 is never presented.
- Synchronous reset asserted in SKID state -> at the next edge state=EMPTY, all outputs 0. With rst_n=0 between edges, outputs do not change (synchronous check).

Source files
------------

// File: rtl/id_ex_pkg.sv
// Shared encodings and default widths for the decode/execute pipeline register.
package id_ex_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int REG_ADDR_W_DEF = 3;
  localparam int CTRL_W_DEF     = 8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b10
  } state_e;

  localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_entry_reg.sv
// One load-enabled instruction bundle (operands, destination, control).
// Cleared only by reset; flush leaves contents stale on purpose.
module id_ex_entry_reg
  import id_ex_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_W_DEF,
  parameter int REG_ADDR_WIDTH = REG_ADDR_W_DEF,
  parameter int CTRL_WIDTH     = CTRL_W_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      ld_i,
  input  logic [DATA_WIDTH-1:0]     data_top_i,
  input  logic [DATA_WIDTH-1:0]     data_bot_i,
  input  logic [REG_ADDR_WIDTH-1:0] dest_reg_i,
  input  logic [CTRL_WIDTH-1:0]     ctrl_i,
  output logic [DATA_WIDTH-1:0]     data_top_o,
  output logic [DATA_WIDTH-1:0]     data_bot_o,
  output logic [REG_ADDR_WIDTH-1:0] dest_reg_o,
  output logic [CTRL_WIDTH-1:0]     ctrl_o
);

  logic [DATA_WIDTH-1:0]     data_top_q, data_bot_q;
  logic [REG_ADDR_WIDTH-1:0] dest_reg_q;
  logic [CTRL_WIDTH-1:0]     ctrl_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_top_q <= '0;
      data_bot_q <= '0;
      dest_reg_q <= '0;
      ctrl_q     <= '0;
    end else if (ld_i) begin
      data_top_q <= data_top_i;
      data_bot_q <= data_bot_i;
      dest_reg_q <= dest_reg_i;
      ctrl_q     <= ctrl_i;
    end
  end

  assign data_top_o = data_top_q;
  assign data_bot_o = data_bot_q;
  assign dest_reg_o = dest_reg_q;
  assign ctrl_o     = ctrl_q;

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register with valid/ready handshake and a one-entry skid buffer.
// id_ready depends only on registered state, breaking the ex_ready -> id_ready path.
module id_ex_pipeline_reg
  import id_ex_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_W_DEF,
  parameter int REG_ADDR_WIDTH = REG_ADDR_W_DEF,
  parameter int CTRL_WIDTH     = CTRL_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      id_valid,
  output logic                      id_ready,
  input  logic [DATA_WIDTH-1:0]     id_data_top,
  input  logic [DATA_WIDTH-1:0]     id_data_bot,
  input  logic [REG_ADDR_WIDTH-1:0] id_dest_reg,
  input  logic [CTRL_WIDTH-1:0]     id_ctrl,
  output logic                      ex_valid,
  input  logic                      ex_ready,
  output logic [DATA_WIDTH-1:0]     ex_data_top,
  output logic [DATA_WIDTH-1:0]     ex_data_bot,
  output logic [REG_ADDR_WIDTH-1:0] ex_dest_reg,
  output logic [CTRL_WIDTH-1:0]     ex_ctrl
);

  state_e state_q, state_d;
  logic   in_fire, out_fire;
  logic   main_ld, skid_ld, main_from_skid;

  logic [DATA_WIDTH-1:0]     skid_top, skid_bot, main_top_d, main_bot_d;
  logic [REG_ADDR_WIDTH-1:0] skid_dest, main_dest_d;
  logic [CTRL_WIDTH-1:0]     skid_ctrl, main_ctrl_d, main_ctrl;

  assign in_fire  = id_valid & id_ready;
  assign out_fire = ex_valid & ex_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // Flush wins over every transfer and suppresses all loads.
  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_fire) begin
          state_d = ST_FULL;
          main_ld = 1'b1;
        end
        ST_FULL: begin
          case ({in_fire, out_fire})
            2'b11: main_ld = 1'b1;
            2'b10: begin
              state_d = ST_SKID;
              skid_ld = 1'b1;
            end
            2'b01: state_d = ST_EMPTY;
            default: ;
          endcase
        end
        ST_SKID: if (out_fire) begin
          state_d        = ST_FULL;
          main_ld        = 1'b1;
          main_from_skid = 1'b1;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    id_ready = (state_q != ST_SKID);
    ex_valid = (state_q != ST_EMPTY);
    ex_ctrl  = ex_valid ? main_ctrl : CTRL_WIDTH'(CTRL_NOP);
  end

  assign main_top_d  = main_from_skid ? skid_top  : id_data_top;
  assign main_bot_d  = main_from_skid ? skid_bot  : id_data_bot;
  assign main_dest_d = main_from_skid ? skid_dest : id_dest_reg;
  assign main_ctrl_d = main_from_skid ? skid_ctrl : id_ctrl;

  id_ex_entry_reg #(
    .DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH), .CTRL_WIDTH(CTRL_WIDTH)
  ) u_main (
    .clk_i(clk), .rst_ni(rst_n), .ld_i(main_ld),
    .data_top_i(main_top_d), .data_bot_i(main_bot_d),
    .dest_reg_i(main_dest_d), .ctrl_i(main_ctrl_d),
    .data_top_o(ex_data_top), .data_bot_o(ex_data_bot),
    .dest_reg_o(ex_dest_reg), .ctrl_o(main_ctrl)
  );

  id_ex_entry_reg #(
    .DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH), .CTRL_WIDTH(CTRL_WIDTH)
  ) u_skid (
    .clk_i(clk), .rst_ni(rst_n), .ld_i(skid_ld),
    .data_top_i(id_data_top), .data_bot_i(id_data_bot),
    .dest_reg_i(id_dest_reg), .ctrl_i(id_ctrl),
    .data_top_o(skid_top), .data_bot_o(skid_bot),
    .dest_reg_o(skid_dest), .ctrl_o(skid_ctrl)
  );

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Self-checking bench: per-cycle vector table plus a FIFO scoreboard of accepted entries.
module tb_id_ex_pipeline_reg;

  logic       clk = 1'b0;
  logic       rst_n, flush, id_valid, ex_ready;
  logic       id_ready, ex_valid;
  logic [7:0] id_data_top, id_data_bot, id_ctrl;
  logic [2:0] id_dest_reg;
  logic [7:0] ex_data_top, ex_data_bot, ex_ctrl;
  logic [2:0] ex_dest_reg;

  always #5 clk = ~clk;

  id_ex_pipeline_reg dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_data_top(id_data_top), .id_data_bot(id_data_bot),
    .id_dest_reg(id_dest_reg), .id_ctrl(id_ctrl),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_data_top(ex_data_top), .ex_data_bot(ex_data_bot),
    .ex_dest_reg(ex_dest_reg), .ex_ctrl(ex_ctrl)
  );

  typedef struct {
    logic       rst_n, flush, iv, er;
    logic [7:0] top, bot;
    logic [2:0] dest;
    logic [7:0] ctrl;
    logic       exp_v, exp_r;
    logic [7:0] exp_top, exp_ctrl;
  } vec_t;

  typedef struct {
    logic [7:0] top, bot;
    logic [2:0] dest;
    logic [7:0] ctrl;
  } ent_t;

  vec_t vecs[16];
  ent_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic f, logic iv, logic er, logic [7:0] top, logic [7:0] bot,
                              logic [2:0] dest, logic [7:0] ctrl, logic ev, logic er_exp,
                              logic [7:0] etop, logic [7:0] ectrl);
    vec_t v;
    v.rst_n = 1'b1; v.flush = f; v.iv = iv; v.er = er;
    v.top = top; v.bot = bot; v.dest = dest; v.ctrl = ctrl;
    v.exp_v = ev; v.exp_r = er_exp; v.exp_top = etop; v.exp_ctrl = ectrl;
    return v;
  endfunction

  // Drive one cycle; scoreboard pops on out_fire and pushes on accepted input.
  task automatic step(input vec_t v);
    ent_t e, got;
    @(negedge clk);
    rst_n = v.rst_n; flush = v.flush; id_valid = v.iv; ex_ready = v.er;
    id_data_top = v.top; id_data_bot = v.bot; id_dest_reg = v.dest; id_ctrl = v.ctrl;
    #1;
    if (ex_valid && ex_ready && rst_n) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        got.top = ex_data_top; got.bot = ex_data_bot; got.dest = ex_dest_reg; got.ctrl = ex_ctrl;
        chk("sb_top", got.top, e.top);
        chk("sb_bot", got.bot, e.bot);
        chk("sb_dest", got.dest, e.dest);
        chk("sb_ctrl", got.ctrl, e.ctrl);
      end
    end
    if (!rst_n || flush) sb.delete();
    else if (id_valid && id_ready) begin
      e.top = id_data_top; e.bot = id_data_bot; e.dest = id_dest_reg; e.ctrl = id_ctrl;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t r;
    // streaming, ex_ready high
    vecs[0]  = mk(0, 1, 1, 8'h11, 8'h22, 3'd1, 8'h01, 1, 1, 8'h11, 8'h01);
    vecs[1]  = mk(0, 1, 1, 8'h33, 8'h44, 3'd2, 8'h02, 1, 1, 8'h33, 8'h02);
    vecs[2]  = mk(0, 1, 1, 8'h55, 8'h66, 3'd3, 8'h03, 1, 1, 8'h55, 8'h03);
    vecs[3]  = mk(0, 0, 1, 8'h00, 8'h00, 3'd0, 8'h00, 0, 1, 8'h00, 8'h00);
    // skid fill and drain
    vecs[4]  = mk(0, 1, 0, 8'hA1, 8'hA2, 3'd4, 8'h10, 1, 1, 8'hA1, 8'h10);
    vecs[5]  = mk(0, 1, 0, 8'hB1, 8'hB2, 3'd5, 8'h20, 1, 0, 8'hA1, 8'h10);
    vecs[6]  = mk(0, 1, 0, 8'hE7, 8'hE8, 3'd6, 8'h70, 1, 0, 8'hA1, 8'h10);
    vecs[7]  = mk(0, 0, 1, 8'h00, 8'h00, 3'd0, 8'h00, 1, 1, 8'hB1, 8'h20);
    vecs[8]  = mk(0, 0, 1, 8'h00, 8'h00, 3'd0, 8'h00, 0, 1, 8'h00, 8'h00);
    // flush while in SKID with a new instruction offered
    vecs[9]  = mk(0, 1, 0, 8'hD1, 8'hD2, 3'd1, 8'h30, 1, 1, 8'hD1, 8'h30);
    vecs[10] = mk(0, 1, 0, 8'hD3, 8'hD4, 3'd2, 8'h31, 1, 0, 8'hD1, 8'h30);
    vecs[11] = mk(1, 1, 0, 8'hC1, 8'hC2, 3'd3, 8'h40, 0, 1, 8'h00, 8'h00);
    vecs[12] = mk(0, 0, 1, 8'h00, 8'h00, 3'd0, 8'h00, 0, 1, 8'h00, 8'h00);
    // flush in FULL with simultaneous in_fire and out_fire
    vecs[13] = mk(0, 1, 1, 8'hE1, 8'hE2, 3'd7, 8'h50, 1, 1, 8'hE1, 8'h50);
    vecs[14] = mk(1, 1, 1, 8'hF1, 8'hF2, 3'd6, 8'h60, 0, 1, 8'h00, 8'h00);
    vecs[15] = mk(0, 0, 1, 8'h00, 8'h00, 3'd0, 8'h00, 0, 1, 8'h00, 8'h00);

    // reset held two cycles with id_valid asserted
    r = mk(0, 1, 1, 8'h99, 8'h98, 3'd7, 8'hFF, 0, 1, 8'h00, 8'h00);
    r.rst_n = 1'b0;
    step(r);
    step(r);
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_id_ready", id_ready, 1);
    chk("rst_ex_ctrl", ex_ctrl, 0);
    chk("rst_top", ex_data_top, 0);
    chk("rst_bot", ex_data_bot, 0);
    chk("rst_dest", ex_dest_reg, 0);

    foreach (vecs[i]) begin
      step(vecs[i]);
      chk($sformatf("v%0d_ex_valid", i), ex_valid, vecs[i].exp_v);
      chk($sformatf("v%0d_id_ready", i), id_ready, vecs[i].exp_r);
      chk($sformatf("v%0d_ex_ctrl", i), ex_ctrl, vecs[i].exp_ctrl);
      if (vecs[i].exp_v) chk($sformatf("v%0d_top", i), ex_data_top, vecs[i].exp_top);
    end
    chk("sb_drained", sb.size(), 0);

    // hold stability: A held under back-pressure across several cycles
    step(mk(0, 1, 0, 8'h61, 8'h62, 3'd3, 8'h0A, 1, 1, 8'h61, 8'h0A));
    step(mk(0, 1, 0, 8'h71, 8'h72, 3'd4, 8'h0B, 1, 0, 8'h61, 8'h0A));
    for (int k = 0; k < 3; k++) begin
      step(mk(0, 1, 0, 8'h81, 8'h82, 3'd5, 8'h0C, 1, 0, 8'h61, 8'h0A));
      chk("hold_top", ex_data_top, 8'h61);
      chk("hold_bot", ex_data_bot, 8'h62);
      chk("hold_dest", ex_dest_reg, 3'd3);
      chk("hold_ctrl", ex_ctrl, 8'h0A);
      chk("hold_ready", id_ready, 0);
    end

    // synchronous reset while in SKID: no change between edges, cleared at the edge
    @(negedge clk);
    rst_n = 1'b0; id_valid = 1'b1; ex_ready = 1'b0; flush = 1'b1;
    #2;
    chk("srst_async_valid", ex_valid, 1);
    chk("srst_async_top", ex_data_top, 8'h61);
    chk("srst_async_ready", id_ready, 0);
    @(posedge clk);
    #1;
    sb.delete();
    chk("srst_valid", ex_valid, 0);
    chk("srst_ready", id_ready, 1);
    chk("srst_ctrl", ex_ctrl, 0);
    chk("srst_top", ex_data_top, 0);
    chk("srst_bot", ex_data_bot, 0);
    chk("srst_dest", ex_dest_reg, 0);
    // skid contents must not resurface after reset release
    step(mk(0, 0, 1, 8'h00, 8'h00, 3'd0, 8'h00, 0, 1, 8'h00, 8'h00));
    chk("post_rst_valid", ex_valid, 0);
    step(mk(0, 1, 1, 8'h5A, 8'hA5, 3'd2, 8'h77, 1, 1, 8'h5A, 8'h77));
    chk("post_rst_top", ex_data_top, 8'h5A);
    chk("post_rst_bot", ex_data_bot, 8'hA5);
    chk("post_rst_ctrl", ex_ctrl, 8'h77);
    step(mk(0, 0, 1, 8'h00, 8'h00, 3'd0, 8'h00, 0, 1, 8'h00, 8'h00));
    chk("final_sb_empty", sb.size(), 0);
    chk("final_valid", ex_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
